vm_fetch_sequencer: RTL and testbench

- Program sequencer for the VM execution core: fetches 64-bit instructions from the program buffer and issues them in order to the instruction decoder/execute path.
- Applies redirects when the branch unit resolves a taken branch.
- At program end: drains the pipeline, hands control to the loop-epilogue (scratchpad mix) logic, then repeats the program for a fixed number of iterations.

---
 rtl/vm_fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_vm_fetch_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vm_fetch_sequencer.sv
// rtl/vm_fetch_sequencer.sv - program fetch/issue sequencer with redirect, drain and iteration loop
module vm_fetch_sequencer #(
  parameter int PROG_LEN = 256,
  parameter int ITER_CNT = 2048,
  parameter int ITER_W   = 11
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start_i,
  output logic [7:0]        prog_addr_o,
  output logic              prog_rd_o,
  input  logic [63:0]       prog_data_i,
  output logic [63:0]       instr_o,
  output logic              instr_v_o,
  input  logic              issue_ready_i,
  input  logic              branch_taken_i,
  input  logic [7:0]        branch_target_i,
  input  logic              exec_idle_i,
  output logic              loop_v_o,
  input  logic              loop_ack_i,
  output logic [ITER_W-1:0] iter_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [7:0]        LAST_PC   = 8'(PROG_LEN - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITER_CNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_LOOP,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        pc_q, pc_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [63:0]       buf0_q, buf0_d;
  logic [63:0]       buf1_q, buf1_d;

  logic              fetching;
  logic              redirect;
  logic              push;
  logic              pop;
  logic [2:0]        occ_after;

  always_comb begin
    fetching    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    redirect    = fetching && branch_taken_i;
    instr_v_o   = (cnt_q != 2'd0) && !redirect;
    instr_o     = rd_ptr_q ? buf1_q : buf0_q;
    pop         = instr_v_o && issue_ready_i;
    // Returning data is dropped in a redirect cycle; that is the kill of the in-flight read.
    push        = inflight_q && !redirect;
    occ_after   = 3'(cnt_q) + {2'b00, inflight_q} - {2'b00, pop};
    prog_rd_o   = (state_q == ST_RUN) && !branch_taken_i && (occ_after < 3'd2);
    prog_addr_o = pc_q;
    loop_v_o    = (state_q == ST_LOOP);
    busy_o      = fetching || (state_q == ST_LOOP);
    done_o      = (state_q == ST_DONE);
    iter_o      = iter_q;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iter_d     = iter_q;
    inflight_d = prog_rd_o;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;

    if (redirect) begin
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        if (wr_ptr_q) buf1_d = prog_data_i;
        else          buf0_d = prog_data_i;
        wr_ptr_d = !wr_ptr_q;
      end
      if (pop) rd_ptr_d = !rd_ptr_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_RUN;
          pc_d    = 8'd0;
          iter_d  = '0;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          pc_d = branch_target_i;
        end else if (prog_rd_o) begin
          // pc parks on the last address rather than wrapping.
          if (pc_q == LAST_PC) state_d = ST_DRAIN;
          else                 pc_d    = pc_q + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          state_d = ST_RUN;
          pc_d    = branch_target_i;
        end else if ((cnt_q == 2'd0) && !inflight_q && exec_idle_i) begin
          state_d = ST_LOOP;
        end
      end
      ST_LOOP: begin
        if (loop_ack_i) begin
          if (iter_q == LAST_ITER) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            iter_d  = iter_q + ITER_W'(1);
            pc_d    = 8'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      pc_q       <= 8'd0;
      iter_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      buf0_q     <= 64'd0;
      buf1_q     <= 64'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iter_q     <= iter_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule

// File: tb/tb_vm_fetch_sequencer.sv
// tb/tb_vm_fetch_sequencer.sv - randomized bench for vm_fetch_sequencer against a program-order reference model
module tb_vm_fetch_sequencer;

  localparam int PROG_LEN = 256;
  localparam int ITER_CNT = 4;
  localparam int ITER_W   = 2;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              start_i = 1'b0;
  logic [7:0]        prog_addr_o;
  logic              prog_rd_o;
  logic [63:0]       prog_data_i = 64'd0;
  logic [63:0]       instr_o;
  logic              instr_v_o;
  logic              issue_ready_i = 1'b0;
  logic              branch_taken_i = 1'b0;
  logic [7:0]        branch_target_i = 8'd0;
  logic              exec_idle_i = 1'b0;
  logic              loop_v_o;
  logic              loop_ack_i = 1'b0;
  logic [ITER_W-1:0] iter_o;
  logic              busy_o;
  logic              done_o;

  vm_fetch_sequencer #(
    .PROG_LEN(PROG_LEN),
    .ITER_CNT(ITER_CNT),
    .ITER_W  (ITER_W)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .start_i        (start_i),
    .prog_addr_o    (prog_addr_o),
    .prog_rd_o      (prog_rd_o),
    .prog_data_i    (prog_data_i),
    .instr_o        (instr_o),
    .instr_v_o      (instr_v_o),
    .issue_ready_i  (issue_ready_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .exec_idle_i    (exec_idle_i),
    .loop_v_o       (loop_v_o),
    .loop_ack_i     (loop_ack_i),
    .iter_o         (iter_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  logic [63:0] prog_mem [PROG_LEN];
  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle/done, 1 fetching, 2 waiting for epilogue ack.
  int   m_phase, m_fa, m_arch, m_cnt, m_iter;
  bit   m_inf, m_done;
  bit   rd_seen;
  logic [7:0] addr_seen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_fa = 0; m_arch = 0; m_cnt = 0; m_iter = 0;
    m_inf = 1'b0; m_done = 1'b0;
  endtask

  task automatic drive_data();
    prog_data_i = rd_seen ? prog_mem[addr_seen] : {$urandom, $urandom};
  endtask

  always @(negedge clk) begin : monitor
    bit exp_v, exp_rd, pop, to_loop;
    rd_seen   = prog_rd_o;
    addr_seen = prog_addr_o;
    if (!nreset) begin
      check_eq("rst_rd", prog_rd_o, 0);
      check_eq("rst_instr_v", instr_v_o, 0);
      check_eq("rst_loop_v", loop_v_o, 0);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_done", done_o, 0);
      check_eq("rst_iter", iter_o, 0);
      check_eq("rst_addr", prog_addr_o, 0);
      check_eq("rst_instr", instr_o, 0);
      model_reset();
    end else begin
      check_eq("busy", busy_o, m_phase != 0);
      check_eq("loop_v", loop_v_o, m_phase == 2);
      check_eq("done", done_o, m_done);
      check_eq("iter", iter_o, 64'(m_iter));
      exp_v = 1'b0; exp_rd = 1'b0; pop = 1'b0; to_loop = 1'b0;
      if (m_phase == 1) begin
        exp_v   = (m_cnt > 0) && !branch_taken_i;
        pop     = exp_v && issue_ready_i;
        exp_rd  = !branch_taken_i && (m_fa < PROG_LEN) && ((m_cnt + int'(m_inf) - int'(pop)) < 2);
        to_loop = !branch_taken_i && (m_fa == PROG_LEN) && (m_cnt == 0) && !m_inf && exec_idle_i;
      end
      check_eq("instr_v", instr_v_o, exp_v);
      check_eq("prog_rd", prog_rd_o, exp_rd);
      if (pop && m_arch < PROG_LEN) check_eq("instr", instr_o, prog_mem[m_arch]);
      if (exp_rd && prog_rd_o) check_eq("prog_addr", prog_addr_o, 64'(m_fa));
      case (m_phase)
        0: if (start_i) begin
          m_phase = 1; m_fa = 0; m_arch = 0; m_iter = 0; m_done = 1'b0; m_cnt = 0; m_inf = 1'b0;
        end
        1: if (branch_taken_i) begin
          m_cnt = 0; m_inf = 1'b0;
          m_fa = int'(branch_target_i); m_arch = int'(branch_target_i);
        end else begin
          if (pop) m_arch++;
          m_cnt = m_cnt + int'(m_inf) - int'(pop);
          m_inf = exp_rd;
          if (exp_rd) m_fa++;
          if (to_loop) m_phase = 2;
        end
        default: if (loop_ack_i) begin
          if (m_iter == ITER_CNT - 1) begin
            m_phase = 0; m_done = 1'b1;
          end else begin
            m_iter++; m_phase = 1; m_fa = 0; m_arch = 0;
          end
        end
      endcase
    end
  end

  // mode 0 straight line, 1 backpressure + random redirects, 2 redirect 100->40, 3 late redirect to 250
  task automatic run_prog(input int mode);
    int cyc, wait_cnt, delay, br_left;
    bit fired;
    cyc = 0; wait_cnt = 0; fired = 1'b0; br_left = 6;
    delay = (mode == 1) ? 5 : ((mode == 0) ? 0 : int'($urandom_range(0, 5)));
    @(posedge clk); #1;
    drive_data();
    start_i = 1'b1; branch_taken_i = 1'b0; loop_ack_i = 1'b0;
    issue_ready_i = 1'b1; exec_idle_i = 1'b1;
    do begin
      @(posedge clk); #1;
      drive_data();
      start_i = (mode == 0) && (cyc == 50);
      branch_taken_i = 1'b0;
      loop_ack_i = 1'b0;
      branch_target_i = 8'($urandom);
      case (mode)
        0, 2:    issue_ready_i = 1'b1;
        1:       issue_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: issue_ready_i = ($urandom % 4) != 0;
      endcase
      exec_idle_i = (mode == 0 || mode == 2) ? 1'b1 : (($urandom % 4) != 0);
      if (m_phase == 1) begin
        if (mode == 1 && br_left > 0 && ($urandom % 150) == 0) begin
          branch_taken_i = 1'b1; br_left--;
        end
        if (mode == 2 && !fired && m_arch == 100 && m_cnt > 0 && m_inf) begin
          branch_taken_i = 1'b1; branch_target_i = 8'd40; fired = 1'b1;
        end
        if (mode == 3 && !fired && m_fa == PROG_LEN) begin
          branch_taken_i = 1'b1; branch_target_i = 8'd250; fired = 1'b1;
        end
      end else if (m_phase == 2) begin
        branch_taken_i = (mode == 1) && (($urandom % 3) == 0);
        if (wait_cnt >= delay) begin
          loop_ack_i = 1'b1; wait_cnt = 0;
          delay = (mode == 1) ? 5 : ((mode == 0) ? 0 : int'($urandom_range(0, 5)));
        end else begin
          wait_cnt++;
        end
      end
      if (m_phase != 2 && mode == 1) loop_ack_i = ($urandom % 16) == 0;
      cyc++;
    end while (!(m_done && m_phase == 0) && cyc < 20000);
    check_eq("run_timeout", cyc < 20000, 1);
    check_eq("final_done", done_o, 1);
    check_eq("final_busy", busy_o, 0);
    check_eq("final_iter", iter_o, ITER_CNT - 1);
    if (mode >= 2) check_eq("branch_fired", fired, 1);
    loop_ack_i = 1'b0; branch_taken_i = 1'b0;
  endtask

  task automatic reset_mid_run();
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    drive_data();
    start_i = 1'b1; issue_ready_i = 1'b0; exec_idle_i = 1'b1;
    branch_taken_i = 1'b0; loop_ack_i = 1'b0;
    do begin
      @(posedge clk); #1;
      drive_data();
      start_i = 1'b0;
      cyc++;
    end while (m_cnt < 2 && cyc < 50);
    check_eq("rst_prep_timeout", cyc < 50, 1);
    check_eq("pre_rst_busy", busy_o, 1);
    nreset = 1'b0;
    #1;
    check_eq("async_rst_rd", prog_rd_o, 0);
    check_eq("async_rst_instr_v", instr_v_o, 0);
    check_eq("async_rst_busy", busy_o, 0);
    check_eq("async_rst_loop_v", loop_v_o, 0);
    check_eq("async_rst_done", done_o, 0);
    check_eq("async_rst_iter", iter_o, 0);
    check_eq("async_rst_instr", instr_o, 0);
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < PROG_LEN; i++) prog_mem[i] = {$urandom, $urandom};
    model_reset();
    rd_seen = 1'b0;
    addr_seen = 8'd0;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    run_prog(0);
    run_prog(1);
    run_prog(2);
    run_prog(3);
    reset_mid_run();
    run_prog(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
